// File: rtl/anim_phase_ctrl_pkg.sv
// Shared constants and speed-level encoding for the ring animation path.
// Used by the phase controller and by the ring renderer.
package anim_phase_ctrl_pkg;

    typedef enum logic [1:0] {
        SPD_1X = 2'd0,
        SPD_2X = 2'd1,
        SPD_4X = 2'd2,
        SPD_8X = 2'd3
    } speed_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;
    localparam int unsigned PHASE_W_DEF         = 8;

    // Steps 1x -> 2x -> 4x -> 8x and wraps back to 1x.
    function automatic speed_e next_speed(input speed_e s);
        logic [1:0] w_lvl;
        w_lvl = s;
        w_lvl = w_lvl + 2'd1;
        return speed_e'(w_lvl);
    endfunction

endpackage

// File: rtl/anim_phase_ctrl_debounce_sync.sv
// Two-flop synchronizer followed by a counting debouncer for one raw input.
// The output flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
module debounce_sync
    import anim_phase_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_deb
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any sample agreeing with the current value restarts the run.
            if (r_sync2 != r_deb) begin
                if (r_cnt == CNT_MAX) begin
                    r_deb <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/anim_phase_ctrl.sv
// Animation phase controller: debounced speed/pause/direction controls, committed
// once per frame, drive a phase accumulator stepped by 2^speed on each frame start.
module anim_phase_ctrl
    import anim_phase_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned PHASE_W         = PHASE_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               speed_btn,
    input  logic               pause_btn,
    input  logic               dir_sw,
    output logic [PHASE_W-1:0] anim_offset,
    output logic               direction,
    output logic [1:0]         speed_level,
    output logic               paused
);

    logic w_spd_deb;
    logic w_pause_deb;
    logic w_dir_deb;

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_spd_db (
        .clk   (clk),
        .rst_n (rst_n),
        .i_raw (speed_btn),
        .o_deb (w_spd_deb)
    );

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
        .clk   (clk),
        .rst_n (rst_n),
        .i_raw (pause_btn),
        .o_deb (w_pause_deb)
    );

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir_db (
        .clk   (clk),
        .rst_n (rst_n),
        .i_raw (dir_sw),
        .o_deb (w_dir_deb)
    );

    logic               r_spd_prev;
    logic               r_pause_prev;
    logic               r_fs_prev;
    speed_e             r_pend_spd;
    logic               r_pend_pause;
    speed_e             r_com_spd;
    logic               r_com_pause;
    logic               r_com_dir;
    logic [PHASE_W-1:0] r_phase;

    logic               w_spd_evt;
    logic               w_pause_evt;
    logic               w_fs;
    logic [PHASE_W-1:0] w_step;

    assign w_spd_evt   = w_spd_deb & ~r_spd_prev;
    assign w_pause_evt = w_pause_deb & ~r_pause_prev;
    assign w_fs        = frame_start & ~r_fs_prev;
    assign w_step      = PHASE_W'(1) << r_com_spd;

    // Commit and phase update read the register values from before this edge, so an
    // event landing on a frame start is only picked up by the next frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spd_prev   <= 1'b0;
            r_pause_prev <= 1'b0;
            r_fs_prev    <= 1'b0;
            r_pend_spd   <= SPD_1X;
            r_pend_pause <= 1'b0;
            r_com_spd    <= SPD_1X;
            r_com_pause  <= 1'b0;
            r_com_dir    <= 1'b0;
            r_phase      <= '0;
        end else begin
            r_spd_prev   <= w_spd_deb;
            r_pause_prev <= w_pause_deb;
            r_fs_prev    <= frame_start;
            if (w_spd_evt) begin
                r_pend_spd <= next_speed(r_pend_spd);
            end
            if (w_pause_evt) begin
                r_pend_pause <= ~r_pend_pause;
            end
            if (w_fs) begin
                r_com_spd   <= r_pend_spd;
                r_com_pause <= r_pend_pause;
                r_com_dir   <= w_dir_deb;
                if (!r_com_pause) begin
                    r_phase <= r_com_dir ? (r_phase - w_step) : (r_phase + w_step);
                end
            end
        end
    end

    assign anim_offset = r_phase;
    assign direction   = r_com_dir;
    assign speed_level = r_com_spd;
    assign paused      = r_com_pause;

endmodule

// File: tb/tb_anim_phase_ctrl.sv
// Directed bench for anim_phase_ctrl with DEBOUNCE_CYCLES=4; a small model pushes the
// expected outputs for each frame start into a queue that is popped after the edge.
module tb_anim_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       speed_btn;
    logic       pause_btn;
    logic       dir_sw;
    logic [7:0] anim_offset;
    logic       direction;
    logic [1:0] speed_level;
    logic       paused;

    always #5 clk = ~clk;

    anim_phase_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .PHASE_W         (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .speed_btn   (speed_btn),
        .pause_btn   (pause_btn),
        .dir_sw      (dir_sw),
        .anim_offset (anim_offset),
        .direction   (direction),
        .speed_level (speed_level),
        .paused      (paused)
    );

    typedef struct packed {
        logic [7:0] off;
        logic       dir;
        logic [1:0] spd;
        logic       pse;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] m_phase;
    logic [1:0] m_pend_spd;
    logic [1:0] m_com_spd;
    logic       m_pend_pause;
    logic       m_com_pause;
    logic       m_pend_dir;
    logic       m_com_dir;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase      = 8'h00;
        m_pend_spd   = 2'd0;
        m_com_spd    = 2'd0;
        m_pend_pause = 1'b0;
        m_com_pause  = 1'b0;
        m_pend_dir   = 1'b0;
        m_com_dir    = 1'b0;
    endtask

    // Phase update uses the committed settings from before the frame, then commits.
    task automatic model_frame();
        exp_t e;
        if (!m_com_pause) begin
            if (m_com_dir) m_phase = m_phase - (8'd1 << m_com_spd);
            else           m_phase = m_phase + (8'd1 << m_com_spd);
        end
        m_com_spd   = m_pend_spd;
        m_com_pause = m_pend_pause;
        m_com_dir   = m_pend_dir;
        e.off = m_phase;
        e.dir = m_com_dir;
        e.spd = m_com_spd;
        e.pse = m_com_pause;
        sb.push_back(e);
    endtask

    task automatic sample_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_offset"}, 32'(anim_offset), 32'(e.off));
            check({tag, "_dir"},    32'(direction),   32'(e.dir));
            check({tag, "_speed"},  32'(speed_level), 32'(e.spd));
            check({tag, "_paused"}, 32'(paused),      32'(e.pse));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input string tag);
        @(negedge clk);
        frame_start = 1'b1;
        model_frame();
        @(posedge clk);
        #1;
        sample_sb(tag);
        @(negedge clk);
        frame_start = 1'b0;
        idle(2);
    endtask

    task automatic press(input int sel, input int hold);
        @(negedge clk);
        if (sel == 0) speed_btn = 1'b1;
        else          pause_btn = 1'b1;
        repeat (hold) @(negedge clk);
        speed_btn = 1'b0;
        pause_btn = 1'b0;
        idle(12);
    endtask

    initial begin
        rst_n       = 1'b1;
        frame_start = 1'b0;
        speed_btn   = 1'b0;
        pause_btn   = 1'b0;
        dir_sw      = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_offset", 32'(anim_offset), 32'h00);
        check("rst_dir",    32'(direction),   32'h0);
        check("rst_speed",  32'(speed_level), 32'h0);
        check("rst_paused", 32'(paused),      32'h0);
        idle(3);
        rst_n = 1'b1;
        idle(3);

        // Free-running at 1x outward.
        for (int i = 0; i < 3; i++) frame("idle");

        // A 3-cycle glitch is shorter than the debounce interval.
        press(0, 3);
        check("short_press_speed", 32'(speed_level), 32'h0);

        // Held press: pending advances, committed waits for the frame.
        press(0, 10);
        m_pend_spd = 2'd1;
        check("speed_before_frame", 32'(speed_level), 32'h0);
        frame("spd1_commit");
        frame("spd1_step");
        frame("spd1_step");
        frame("spd1_step");

        press(0, 10);
        press(0, 10);
        m_pend_spd = 2'd3;
        frame("spd3_commit");
        for (int i = 0; i < 30; i++) frame("spd3_run");
        check("phase_fc",  32'(anim_offset), 32'hFC);
        check("speed_is3", 32'(speed_level), 32'h3);
        press(0, 10);
        m_pend_spd = 2'd0;
        frame("spd_wrap");
        check("phase_wrap_04", 32'(anim_offset), 32'h04);
        check("speed_wrap_0",  32'(speed_level), 32'h0);

        // Inward direction, underflow through zero.
        @(negedge clk);
        dir_sw = 1'b1;
        idle(12);
        m_pend_dir = 1'b1;
        frame("dir_commit");
        for (int i = 0; i < 4; i++) frame("dir_in");
        check("phase_01", 32'(anim_offset), 32'h01);
        frame("dir_in");
        check("phase_00", 32'(anim_offset), 32'h00);
        frame("dir_in");
        check("phase_ff", 32'(anim_offset), 32'hFF);
        dir_sw = 1'b0;
        idle(12);
        m_pend_dir = 1'b0;
        frame("dir_out");

        // A frame_start held for several cycles counts once.
        @(negedge clk);
        frame_start = 1'b1;
        model_frame();
        @(posedge clk);
        #1;
        sample_sb("long_fs");
        repeat (3) @(posedge clk);
        #1;
        check("long_fs_hold", 32'(anim_offset), 32'(m_phase));
        @(negedge clk);
        frame_start = 1'b0;
        idle(2);

        // Pause event lands on the same edge as a frame start.
        @(negedge clk);
        pause_btn = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        frame_start = 1'b1;
        model_frame();
        m_pend_pause = 1'b1;
        @(posedge clk);
        #1;
        sample_sb("pause_coincide");
        @(negedge clk);
        frame_start = 1'b0;
        repeat (6) @(negedge clk);
        pause_btn = 1'b0;
        idle(12);
        frame("pause_commit");
        check("paused_high", 32'(paused), 32'h1);
        for (int i = 0; i < 5; i++) frame("frozen");

        press(1, 10);
        m_pend_pause = 1'b0;
        frame("unpause_commit");
        for (int i = 0; i < 256 && m_phase != 8'h37; i++) frame("seek");
        check("phase_37", 32'(anim_offset), 32'h37);

        // Reset in the middle of a debounce run.
        @(negedge clk);
        speed_btn = 1'b1;
        idle(3);
        rst_n = 1'b0;
        #1;
        check("rst2_offset", 32'(anim_offset), 32'h00);
        check("rst2_dir",    32'(direction),   32'h0);
        check("rst2_speed",  32'(speed_level), 32'h0);
        check("rst2_paused", 32'(paused),      32'h0);
        model_reset();
        speed_btn = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(20);
        frame("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
